// File: rtl/entity_slot_scheduler.sv
// entity_slot_scheduler: round-robin arbitration of entity writes into a shadow
// bank, copied to the active bank at the per-frame commit point.
module entity_slot_scheduler #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned NUM_SLOTS = 9,
  parameter int unsigned V_COMMIT  = 480,
  parameter int unsigned H_COMMIT  = 0,
  localparam int unsigned SLOT_W   = 4,
  localparam int unsigned DATA_W   = 14,
  localparam int unsigned CNT_W    = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [SLOT_W*NUM_REQ-1:0]   req_slot,
  input  logic [DATA_W*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [CNT_W-1:0]            counter_V,
  input  logic [CNT_W-1:0]            counter_H,
  output logic [DATA_W*NUM_SLOTS-1:0] entity_flat,
  output logic                        frame_tick,
  output logic [3:0]                  write_count,
  output logic                        slot_err
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DATA_W-1:0] EMPTY_WORD = 14'h3C00;

  logic [DATA_W-1:0] r_shadow [NUM_SLOTS];
  logic [DATA_W-1:0] r_active [NUM_SLOTS];
  logic [PTR_W-1:0]  r_ptr;
  logic              r_frame_tick;
  logic [3:0]        r_write_count;
  logic              r_slot_err;

  logic               w_commit;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_win;
  logic               w_found;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [SLOT_W-1:0]  w_slot;
  logic [DATA_W-1:0]  w_data;
  logic               w_slot_ok;

  assign w_commit = (counter_V == CNT_W'(V_COMMIT)) && (counter_H == CNT_W'(H_COMMIT));

  // Round-robin search from r_ptr; grants suppressed in reset and on the commit cycle
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!w_found && req_valid[i] && (i == ((32'(r_ptr) + k) % NUM_REQ))) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_win      = PTR_W'(i);
        end
      end
    end
    if (!rst_n || w_commit) begin
      w_grant = '0;
      w_found = 1'b0;
    end
  end

  assign req_ready  = w_grant;
  assign w_ptr_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);

  // Select the winning requester's slot and data word
  always_comb begin
    w_slot = '0;
    w_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_slot = req_slot[SLOT_W*i +: SLOT_W];
        w_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign w_slot_ok = (32'(w_slot) < NUM_SLOTS);

  // Shadow bank absorbs accepted writes; active bank copies it at the commit edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        r_shadow[s] <= EMPTY_WORD;
        r_active[s] <= EMPTY_WORD;
      end
    end else if (w_commit) begin
      r_active <= r_shadow;
    end else if (w_found && w_slot_ok) begin
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (w_slot == SLOT_W'(s)) begin
          r_shadow[s] <= w_data;
        end
      end
    end
  end

  // Arbitration pointer advances past the winner on every transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_next;
    end
  end

  // Frame tick, saturating write counter and sticky bad-slot flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_tick  <= 1'b0;
      r_write_count <= '0;
      r_slot_err    <= 1'b0;
    end else begin
      r_frame_tick <= w_commit;
      if (w_commit) begin
        r_write_count <= '0;
      end else if (w_found) begin
        if (w_slot_ok) begin
          if (r_write_count != 4'hF) begin
            r_write_count <= r_write_count + 4'd1;
          end
        end else begin
          r_slot_err <= 1'b1;
        end
      end
    end
  end

  // Active bank drives the frame buffer controller straight from registers
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_flat
    assign entity_flat[DATA_W*s +: DATA_W] = r_active[s];
  end

  assign frame_tick  = r_frame_tick;
  assign write_count = r_write_count;
  assign slot_err    = r_slot_err;

endmodule
